cdma_wt_wgs_tracker: RTL and testbench

CDMA_WT_WGS_TRACKER -- requirements
Module: cdma_wt_wgs_tracker

---
 rtl/cdma_wt_wgs_tracker_pkg.sv | 38 +++
 rtl/cdma_wt_wgs_rel_acc.sv | 32 +++
 rtl/cdma_wt_wgs_tracker.sv | 163 ++++++++++++++++
 tb/tb_cdma_wt_wgs_tracker.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdma_wt_wgs_tracker_pkg.sv
// Shared definitions for the CDMA weight-group-status tracker.
//
// Holds the tracker state encoding and the layout of the 32-bit status
// word popped from the WGS fifo:
//   [14:0]  entry count of the group
//   [15]    last-in-layer flag
//   [31:16] group tag
// Small helpers extract each field so the field positions live in one place.
package cdma_wt_wgs_tracker_pkg;

  localparam int unsigned WordW = 32;  // status word width
  localparam int unsigned CntW  = 15;  // entry count / remaining width
  localparam int unsigned TagW  = 16;  // group tag width
  localparam int unsigned TotW  = 20;  // per-layer running total width

  localparam int unsigned CntLsb  = 0;
  localparam int unsigned LastBit = 15;
  localparam int unsigned TagLsb  = 16;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StTrack = 2'd1,
    StDone  = 2'd2
  } state_e;

  function automatic logic [CntW-1:0] word_cnt(input logic [WordW-1:0] word);
    return word[CntLsb +: CntW];
  endfunction

  function automatic logic word_last(input logic [WordW-1:0] word);
    return word[LastBit];
  endfunction

  function automatic logic [TagW-1:0] word_tag(input logic [WordW-1:0] word);
    return word[TagLsb +: TagW];
  endfunction

endpackage

// File: rtl/cdma_wt_wgs_rel_acc.sv
// Saturating subtract for a weight-entry release.
//
// Given the entries still outstanding in the current group and the number
// released this cycle, produces the new outstanding count (floored at 0) and
// the amount actually consumed, i.e. min(rel_entries, remaining). The
// consumed amount is what feeds the per-layer total, so an over-release never
// inflates it past the size of the group.
//
// Ports:
//   remaining_i       entries of the group not yet released
//   rel_entries_i     entries released this cycle
//   remaining_next_o  remaining after the release, saturated at 0
//   consumed_o        entries actually retired from the group
module cdma_wt_wgs_rel_acc
  import cdma_wt_wgs_tracker_pkg::*;
(
  input  logic [CntW-1:0] remaining_i,
  input  logic [CntW-1:0] rel_entries_i,
  output logic [CntW-1:0] remaining_next_o,
  output logic [CntW-1:0] consumed_o
);

  always_comb begin
    remaining_next_o = '0;
    consumed_o       = remaining_i;
    if (rel_entries_i < remaining_i) begin
      remaining_next_o = remaining_i - rel_entries_i;
      consumed_o       = rel_entries_i;
    end
  end

endmodule

// File: rtl/cdma_wt_wgs_tracker.sv
// CDMA weight-group-status tracker.
//
// Pops one status word per group from the WGS fifo, then counts CBUF weight
// entry releases against the group's entry count. When the group is fully
// released it spends one cycle in DONE, pulsing grp_done (and layer_done for
// the last group of a layer), and returns to IDLE to accept the next word.
// layer_total accumulates released entries across groups and clears after
// the DONE cycle of a last-in-layer group.
//
// Ports:
//   clk          single clock
//   reset_       asynchronous active-low reset
//   wgs_req      status word valid
//   wgs_data     status word: [14:0] count, [15] last, [31:16] tag
//   wgs_ready    registered; high only in IDLE, word taken on req && ready
//   rel_valid    entries released this cycle
//   rel_entries  number of entries released
//   remaining    entries of the current group not yet released
//   grp_done     one-cycle pulse, group fully released
//   grp_tag      tag of the current or last group
//   layer_done   pulse with grp_done for a last-in-layer group
//   layer_total  entries released since the last layer_done (mod 2^20)
//   err          sticky protocol error
//
// Build option: define CDMA_WT_WGS_TRACKER_ERR_CHK_EN to build the sticky
// error flag (release outside TRACK, or over-release). Undefined, err is 0.
module cdma_wt_wgs_tracker
  import cdma_wt_wgs_tracker_pkg::*;
(
  input  logic             clk,
  input  logic             reset_,
  input  logic             wgs_req,
  input  logic [WordW-1:0] wgs_data,
  output logic             wgs_ready,
  input  logic             rel_valid,
  input  logic [CntW-1:0]  rel_entries,
  output logic [CntW-1:0]  remaining,
  output logic             grp_done,
  output logic [TagW-1:0]  grp_tag,
  output logic             layer_done,
  output logic [TotW-1:0]  layer_total,
  output logic             err
);

  state_e            state_q, state_d;
  logic              wgs_ready_q, wgs_ready_d;
  logic [CntW-1:0]   remaining_q, remaining_d;
  logic              last_q, last_d;
  logic [TagW-1:0]   tag_q, tag_d;
  logic [TotW-1:0]   total_q, total_d;

  logic              accept;
  logic              rel_act;
  logic [CntW-1:0]   rem_next;
  logic [CntW-1:0]   consumed;
  logic [CntW-1:0]   acc_cnt;

  // wgs_ready_q gates accept, so a word is never taken in the cycle right
  // after reset even though the state is already IDLE.
  assign accept  = (state_q == StIdle) && wgs_ready_q && wgs_req;
  // A zero-entry release is a no-op, so it is filtered out here.
  assign rel_act = (state_q == StTrack) && rel_valid && (rel_entries != '0);
  assign acc_cnt = word_cnt(wgs_data);

  cdma_wt_wgs_rel_acc u_rel_acc (
    .remaining_i      (remaining_q),
    .rel_entries_i    (rel_entries),
    .remaining_next_o (rem_next),
    .consumed_o       (consumed)
  );

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    last_d      = last_q;
    tag_d       = tag_q;
    total_d     = total_q;

    case (state_q)
      StIdle: begin
        if (accept) begin
          remaining_d = acc_cnt;
          last_d      = word_last(wgs_data);
          tag_d       = word_tag(wgs_data);
          // An empty group has nothing to wait for and goes straight to DONE.
          state_d     = (acc_cnt != '0) ? StTrack : StDone;
        end
      end
      StTrack: begin
        if (rel_act) begin
          remaining_d = rem_next;
          total_d     = total_q + TotW'(consumed);
          if (rem_next == '0) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
        if (last_q) begin
          total_d = '0;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    wgs_ready_d = (state_d == StIdle);
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q     <= StIdle;
      wgs_ready_q <= 1'b0;
      remaining_q <= '0;
      last_q      <= 1'b0;
      tag_q       <= '0;
      total_q     <= '0;
    end else begin
      state_q     <= state_d;
      wgs_ready_q <= wgs_ready_d;
      remaining_q <= remaining_d;
      last_q      <= last_d;
      tag_q       <= tag_d;
      total_q     <= total_d;
    end
  end

  assign wgs_ready   = wgs_ready_q;
  assign remaining   = remaining_q;
  assign grp_tag     = tag_q;
  assign layer_total = total_q;
  assign grp_done    = (state_q == StDone);
  assign layer_done  = (state_q == StDone) && last_q;

`ifdef CDMA_WT_WGS_TRACKER_ERR_CHK_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (rel_valid && (state_q != StTrack)) begin
      err_d = 1'b1;
    end
    if (rel_valid && (state_q == StTrack) && (rel_entries > remaining_q)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_cdma_wt_wgs_tracker.sv
// Directed bench for cdma_wt_wgs_tracker. Stimulus pushes the expected
// group-completion record into a queue; a monitor pops it on each grp_done.
module tb_cdma_wt_wgs_tracker;

`ifdef CDMA_WT_WGS_TRACKER_ERR_CHK_EN
  localparam bit ErrEn = 1'b1;
`else
  localparam bit ErrEn = 1'b0;
`endif

  logic        clk;
  logic        reset_;
  logic        wgs_req;
  logic [31:0] wgs_data;
  logic        wgs_ready;
  logic        rel_valid;
  logic [14:0] rel_entries;
  logic [14:0] remaining;
  logic        grp_done;
  logic [15:0] grp_tag;
  logic        layer_done;
  logic [19:0] layer_total;
  logic        err;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [15:0] tag;
    logic        ld;
    logic [19:0] tot;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  cdma_wt_wgs_tracker dut (
    .clk         (clk),
    .reset_      (reset_),
    .wgs_req     (wgs_req),
    .wgs_data    (wgs_data),
    .wgs_ready   (wgs_ready),
    .rel_valid   (rel_valid),
    .rel_entries (rel_entries),
    .remaining   (remaining),
    .grp_done    (grp_done),
    .grp_tag     (grp_tag),
    .layer_done  (layer_done),
    .layer_total (layer_total),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [15:0] tag, input logic ld, input logic [19:0] tot,
                          input logic e);
    exp_t x;
    x.tag = tag;
    x.ld  = ld;
    x.tot = tot;
    x.err = e;
    exp_q.push_back(x);
  endtask

  // Monitor: every grp_done must match the next queued expectation.
  always @(negedge clk) begin
    if (reset_ && layer_done && !grp_done) begin
      chk("layer_done_without_grp_done", 32'(layer_done), 32'(0));
    end
    if (reset_ && grp_done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL grp_done_unexpected: got tag 0x%0h expected no grp_done at %0t",
                 grp_tag, $time);
      end else begin
        mon_e = exp_q.pop_front();
        chk("sb_grp_tag", 32'(grp_tag), 32'(mon_e.tag));
        chk("sb_layer_done", 32'(layer_done), 32'(mon_e.ld));
        chk("sb_layer_total", 32'(layer_total), 32'(mon_e.tot));
        chk("sb_err", 32'(err), 32'(mon_e.err));
        chk("sb_remaining", 32'(remaining), 32'(0));
      end
    end
  end

  initial begin
    reset_      = 1'b0;
    wgs_req     = 1'b0;
    wgs_data    = '0;
    rel_valid   = 1'b0;
    rel_entries = '0;

    // Reset state.
    #12;
    chk("rst_wgs_ready", 32'(wgs_ready), 32'(0));
    chk("rst_remaining", 32'(remaining), 32'(0));
    chk("rst_grp_tag", 32'(grp_tag), 32'(0));
    chk("rst_grp_done", 32'(grp_done), 32'(0));
    chk("rst_layer_done", 32'(layer_done), 32'(0));
    chk("rst_layer_total", 32'(layer_total), 32'(0));
    chk("rst_err", 32'(err), 32'(0));
    tick();
    reset_ = 1'b1;
    #1;
    chk("ready_before_first_edge", 32'(wgs_ready), 32'(0));
    tick();
    chk("ready_after_first_edge", 32'(wgs_ready), 32'(1));

    // Last-in-layer group of 5, one release of 5.
    wgs_data = 32'h0002_8005;
    wgs_req  = 1'b1;
    push_exp(16'h0002, 1'b1, 20'd5, 1'b0);
    tick();
    wgs_req = 1'b0;
    chk("g2_remaining", 32'(remaining), 32'(5));
    chk("g2_tag", 32'(grp_tag), 32'(16'h0002));
    chk("g2_ready_low", 32'(wgs_ready), 32'(0));
    rel_valid   = 1'b1;
    rel_entries = 15'd5;
    tick();
    rel_valid = 1'b0;
    chk("g2_total_in_done", 32'(layer_total), 32'(5));
    tick();
    chk("g2_total_cleared", 32'(layer_total), 32'(0));
    chk("g2_ready_back", 32'(wgs_ready), 32'(1));

    // Group of 3, released 1,1,1.
    wgs_data = 32'h0001_0003;
    wgs_req  = 1'b1;
    push_exp(16'h0001, 1'b0, 20'd3, 1'b0);
    tick();
    wgs_req = 1'b0;
    chk("g1_remaining_3", 32'(remaining), 32'(3));
    rel_valid   = 1'b1;
    rel_entries = 15'd1;
    tick();
    chk("g1_remaining_2", 32'(remaining), 32'(2));
    tick();
    chk("g1_remaining_1", 32'(remaining), 32'(1));
    tick();
    rel_valid = 1'b0;
    chk("g1_remaining_0", 32'(remaining), 32'(0));
    chk("g1_grp_done", 32'(grp_done), 32'(1));
    tick();
    chk("g1_ready_back", 32'(wgs_ready), 32'(1));
    chk("g1_total_kept", 32'(layer_total), 32'(3));

    // Empty group: DONE straight after accept.
    wgs_data = 32'h0003_0000;
    wgs_req  = 1'b1;
    push_exp(16'h0003, 1'b0, 20'd3, 1'b0);
    tick();
    wgs_req = 1'b0;
    chk("g3_grp_done", 32'(grp_done), 32'(1));
    chk("g3_remaining", 32'(remaining), 32'(0));
    tick();
    chk("g3_ready_back", 32'(wgs_ready), 32'(1));

    // Over-release: count 4, release 6.
    wgs_data = 32'h0004_0004;
    wgs_req  = 1'b1;
    push_exp(16'h0004, 1'b0, 20'd7, ErrEn);
    tick();
    wgs_req     = 1'b0;
    rel_valid   = 1'b1;
    rel_entries = 15'd6;
    tick();
    rel_valid = 1'b0;
    chk("g4_remaining_sat", 32'(remaining), 32'(0));
    chk("g4_total", 32'(layer_total), 32'(7));
    tick();

    // Following last-in-layer group: err must stay sticky.
    wgs_data = 32'h0006_8002;
    wgs_req  = 1'b1;
    push_exp(16'h0006, 1'b1, 20'd9, ErrEn);
    tick();
    wgs_req     = 1'b0;
    rel_valid   = 1'b1;
    rel_entries = 15'd2;
    tick();
    rel_valid = 1'b0;
    tick();
    chk("g6_total_cleared", 32'(layer_total), 32'(0));
    chk("g6_err_sticky", 32'(err), 32'(ErrEn));

    // Release while IDLE: ignored.
    rel_valid   = 1'b1;
    rel_entries = 15'd7;
    tick();
    rel_valid = 1'b0;
    chk("idle_rel_total", 32'(layer_total), 32'(0));
    chk("idle_rel_remaining", 32'(remaining), 32'(0));
    chk("idle_rel_ready", 32'(wgs_ready), 32'(1));

    // Reset asserted mid-group with remaining=9.
    wgs_data = 32'h0005_0009;
    wgs_req  = 1'b1;
    tick();
    wgs_req = 1'b0;
    chk("g5_remaining_9", 32'(remaining), 32'(9));
    rel_valid   = 1'b1;
    rel_entries = 15'd0;
    tick();
    rel_valid = 1'b0;
    chk("zero_rel_remaining", 32'(remaining), 32'(9));
    chk("zero_rel_total", 32'(layer_total), 32'(0));
    reset_ = 1'b0;
    #1;
    chk("mid_rst_remaining", 32'(remaining), 32'(0));
    chk("mid_rst_tag", 32'(grp_tag), 32'(0));
    chk("mid_rst_ready", 32'(wgs_ready), 32'(0));
    chk("mid_rst_grp_done", 32'(grp_done), 32'(0));
    chk("mid_rst_err", 32'(err), 32'(0));
    tick();
    reset_ = 1'b1;
    #1;
    chk("post_rst_ready_low", 32'(wgs_ready), 32'(0));
    tick();
    chk("post_rst_ready_high", 32'(wgs_ready), 32'(1));

    // Release in IDLE alone sets err when checking is built in.
    rel_valid   = 1'b1;
    rel_entries = 15'd7;
    tick();
    rel_valid = 1'b0;
    chk("idle_rel_err", 32'(err), 32'(ErrEn));
    chk("idle_rel2_total", 32'(layer_total), 32'(0));

    // Back-to-back words with wgs_req held high: one accept every 3 cycles.
    wgs_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wgs_data = 32'h0010_0001 + (32'(k) << 16);
      chk("b2b_ready_high", 32'(wgs_ready), 32'(1));
      push_exp(16'h0010 + 16'(k), 1'b0, 20'(k + 1), ErrEn);
      tick();
      chk("b2b_tag", 32'(grp_tag), 32'(16'h0010 + 16'(k)));
      chk("b2b_remaining", 32'(remaining), 32'(1));
      chk("b2b_ready_low", 32'(wgs_ready), 32'(0));
      wgs_data    = 32'hFFFF_FFFF;
      rel_valid   = 1'b1;
      rel_entries = 15'd1;
      tick();
      rel_valid = 1'b0;
      chk("b2b_done_ready_low", 32'(wgs_ready), 32'(0));
      tick();
    end
    wgs_req = 1'b0;
    tick();
    tick();
    chk("sb_queue_drained", 32'(exp_q.size()), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
